// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// channels and the decoder-facing instruction channel.
interface instr_fetch_unit_if;
    logic        jump_valid;
    logic [63:0] jump_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    // master: the fetch unit itself; slave: memory, decoder and redirect source.
    modport master (
        input  jump_valid, jump_target,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        output jump_valid, jump_target,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> OUT per instruction,
// with redirect handling that drops in-flight responses fetched from a stale pc.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        bus,
    output logic [1:0]                dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.
    // The memory response has no ready: it is a one-cycle pulse seen only in WAIT.

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] jump_pc;

    assign jump_pc = {bus.jump_target[63:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.jump_valid) pc_d = jump_pc;
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                    // The request just issued carries the old pc; its reply is stale.
                    drop_d  = bus.jump_valid;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (drop_q || bus.jump_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                        if (bus.jump_valid) pc_d = jump_pc;
                    end else begin
                        instr_d = bus.imem_resp_data;
                        state_d = OUT;
                    end
                end else if (bus.jump_valid) begin
                    pc_d   = jump_pc;
                    drop_d = 1'b1;
                end
            end
            OUT: begin
                if (bus.jump_valid) begin
                    pc_d    = jump_pc;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == OUT);
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = pc_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, back-pressure, redirects,
// async reset mid-transaction and pc wrap-around on a second instance.
module tb_instr_fetch_unit;
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_OUT = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_w;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_w;
    int         checks = 0;
    int         errors = 0;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus_w ();

    instr_fetch_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk       (clk),
        .rst       (rst_w),
        .bus       (bus_w),
        .dbg_state (dbg_state_w)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Current cycle must be REQ for pc; completes one fetch with a 1-cycle memory
    // reply and an instruction accepted immediately (3 cycles total).
    task automatic fetch_one(input string tag, input logic [63:0] pc, input logic [31:0] data);
        chk({tag, "_req_state"}, 64'(dbg_state), 64'(S_REQ));
        chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd1);
        chk({tag, "_req_addr"}, bus.imem_req_addr, pc);
        step();
        chk({tag, "_wait_state"}, 64'(dbg_state), 64'(S_WAIT));
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        step();
        bus.imem_resp_valid = 1'b0;
        chk({tag, "_out_valid"}, 64'(bus.instr_valid), 64'd1);
        chk({tag, "_out_instr"}, 64'(bus.instr), 64'(data));
        chk({tag, "_out_pc"}, bus.instr_pc, pc);
        step();
    endtask

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        bus.jump_valid = 1'b0;      bus.jump_target = '0;
        bus.imem_req_ready = 1'b0;  bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0;    bus.instr_ready = 1'b0;
        bus_w.jump_valid = 1'b0;    bus_w.jump_target = '0;
        bus_w.imem_req_ready = 1'b0; bus_w.imem_resp_valid = 1'b0;
        bus_w.imem_resp_data = '0;  bus_w.instr_ready = 1'b0;

        // Reset values are visible before any clock edge.
        #3;
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("rst_instr", 64'(bus.instr), 64'h13);
        chk("rst_instr_pc", bus.instr_pc, 64'h8000_0000);

        step();
        step();
        rst = 1'b0;
        chk("idle_after_rst", 64'(dbg_state), 64'(S_IDLE));
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        step();

        // Sequential fetch.
        fetch_one("seq0", 64'h8000_0000, 32'h1111_0001);
        fetch_one("seq1", 64'h8000_0004, 32'h2222_0002);
        fetch_one("seq2", 64'h8000_0008, 32'h3333_0003);

        // Back-pressure for 5 cycles in OUT.
        bus.instr_ready = 1'b0;
        chk("bp_req_addr", bus.imem_req_addr, 64'h8000_000C);
        step();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h4444_0004;
        step();
        bus.imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.instr_valid), 64'd1);
            chk("bp_instr", 64'(bus.instr), 64'h4444_0004);
            chk("bp_pc", bus.instr_pc, 64'h8000_000C);
            chk("bp_no_req", 64'(bus.imem_req_valid), 64'd0);
            step();
        end
        bus.instr_ready = 1'b1;
        chk("bp_still_out", 64'(dbg_state), 64'(S_OUT));
        step();
        chk("bp_next_addr", bus.imem_req_addr, 64'h8000_0010);

        // Redirect in WAIT two cycles before the response.
        step();
        bus.jump_valid  = 1'b1;
        bus.jump_target = 64'h8000_0103;
        step();
        bus.jump_valid = 1'b0;
        chk("wj_still_wait", 64'(dbg_state), 64'(S_WAIT));
        step();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        step();
        bus.imem_resp_valid = 1'b0;
        chk("wj_dropped", 64'(bus.instr_valid), 64'd0);
        fetch_one("wj_fetch", 64'h8000_0100, 32'h5555_0005);

        // Redirect in OUT with instr_ready high.
        step();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h6666_0006;
        step();
        bus.imem_resp_valid = 1'b0;
        chk("oj_out_pc", bus.instr_pc, 64'h8000_0104);
        bus.jump_valid  = 1'b1;
        bus.jump_target = 64'h8000_0200;
        step();
        bus.jump_valid = 1'b0;
        chk("oj_state", 64'(dbg_state), 64'(S_REQ));
        chk("oj_req_addr", bus.imem_req_addr, 64'h8000_0200);

        // Redirect in REQ while memory stalls, then a stray response in REQ.
        bus.imem_req_ready = 1'b0;
        bus.jump_valid     = 1'b1;
        bus.jump_target    = 64'h8000_0302;
        step();
        bus.jump_valid      = 1'b0;
        chk("rj_state", 64'(dbg_state), 64'(S_REQ));
        chk("rj_req_addr", bus.imem_req_addr, 64'h8000_0300);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD0_0BAD;
        step();
        bus.imem_resp_valid = 1'b0;
        chk("stray_state", 64'(dbg_state), 64'(S_REQ));
        chk("stray_instr", 64'(bus.instr), 64'h6666_0006);

        // Redirect in REQ as the request is accepted: its reply is dropped.
        bus.imem_req_ready = 1'b1;
        bus.jump_valid     = 1'b1;
        bus.jump_target    = 64'h8000_0400;
        step();
        bus.jump_valid = 1'b0;
        chk("aj_state", 64'(dbg_state), 64'(S_WAIT));
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD1_1BAD;
        step();
        bus.imem_resp_valid = 1'b0;
        chk("aj_dropped", 64'(bus.instr_valid), 64'd0);
        fetch_one("aj_fetch", 64'h8000_0400, 32'h7777_0007);

        // Async reset pulse between edges while in WAIT, then a stale response.
        step();
        chk("ar_wait", 64'(dbg_state), 64'(S_WAIT));
        #3 rst = 1'b1;
        #1;
        chk("ar_state", 64'(dbg_state), 64'(S_IDLE));
        chk("ar_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("ar_req_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("ar_instr", 64'(bus.instr), 64'h13);
        chk("ar_instr_pc", bus.instr_pc, 64'h8000_0000);
        #1 rst = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD2_2BAD;
        bus.imem_req_ready  = 1'b0;
        step();
        chk("ar_stale_state", 64'(dbg_state), 64'(S_REQ));
        step();
        bus.imem_resp_valid = 1'b0;
        chk("ar_stale_valid", 64'(bus.instr_valid), 64'd0);
        chk("ar_stale_addr", bus.imem_req_addr, 64'h8000_0000);

        // Wrap-around on the second instance.
        rst_w = 1'b0;
        step();
        chk("wrap_req_addr", bus_w.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus_w.imem_req_ready = 1'b1;
        step();
        bus_w.imem_req_ready  = 1'b0;
        bus_w.imem_resp_valid = 1'b1;
        bus_w.imem_resp_data  = 32'h8888_0008;
        step();
        bus_w.imem_resp_valid = 1'b0;
        chk("wrap_instr_pc", bus_w.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        bus_w.instr_ready = 1'b1;
        step();
        chk("wrap_state", 64'(dbg_state_w), 64'(S_REQ));
        chk("wrap_next_addr", bus_w.imem_req_addr, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
